// File: rtl/nios_fprint_button_pio_db_if.sv
// Avalon-MM slave bus for the debounced button PIO.
// The master drives address/strobes and the slave returns registered read data.
interface nios_fprint_button_pio_db_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_fprint_button_pio_db.sv
// Debounced multi-bit input PIO: two-flop sync, per-bit debounce, edge capture
// with per-bit rise/fall enables, W1C clear and a masked level interrupt.
module nios_fprint_button_pio_db #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INIT_LEVEL      = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios_fprint_button_pio_db_if.slave    avs,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    localparam int             CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;

    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic             wr;
    logic [31:0]      rd_mux;

    assign wr = avs.chipselect & ~avs.write_n;

    // A bit commits when it has differed from stable for the full window.
    always_comb begin
        upd      = '0;
        edge_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i]      = (sync[i] != stable[i]) && (cnt[i] == TC);
            edge_set[i] = upd[i] & ((sync[i] & rise_en[i]) | (~sync[i] & fall_en[i]));
        end
    end

    always_comb begin
        edge_clr = '0;
        if (wr && avs.address == 3'd3)
            edge_clr = avs.writedata[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1     <= INIT_LEVEL;
            sync   <= INIT_LEVEL;
            stable <= INIT_LEVEL;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            d1   <= in_port;
            sync <= d1;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TC) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Set is ORed in after the clear so a same-cycle capture survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= '1;
            fall_en      <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
            if (wr) begin
                case (avs.address)
                    3'd2:    irq_mask <= avs.writedata[WIDTH-1:0];
                    3'd4:    rise_en  <= avs.writedata[WIDTH-1:0];
                    3'd5:    fall_en  <= avs.writedata[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            3'd0:    rd_mux = 32'(stable);
            3'd1:    rd_mux = 32'(sync);
            3'd2:    rd_mux = 32'(irq_mask);
            3'd3:    rd_mux = 32'(edge_capture);
            3'd4:    rd_mux = 32'(rise_en);
            3'd5:    rd_mux = 32'(fall_en);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            avs.readdata <= '0;
        else
            avs.readdata <= rd_mux;
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_fprint_button_pio_db.sv
// Directed bench for the debounced button PIO with DEBOUNCE_CYCLES = 8, WIDTH = 4.
module tb_nios_fprint_button_pio_db;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    logic       irq;
    int         tests;
    int         fails;

    nios_fprint_button_pio_db_if bus ();

    nios_fprint_button_pio_db #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (8),
        .INIT_LEVEL      (4'h0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        check(tag, bus.readdata, exp);
    endtask

    initial begin
        logic [31:0] reset_map [8];
        tests = 0;
        fails = 0;
        reset_map = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0, 32'h0};

        reset_n        = 1'b0;
        in_port        = 4'h0;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;

        for (int a = 0; a < 8; a++)
            rd(3'(a), reset_map[a], $sformatf("reset_addr%0d", a));
        check("reset_irq_after", {31'h0, irq}, 32'h0);

        // Rising edge on bit 0: irq exactly at edge k+9
        wr(3'd2, 32'h1);
        wr(3'd4, 32'h1);
        rd(3'd2, 32'h1, "mask_readback");
        @(negedge clk);
        in_port[0] = 1'b1;
        repeat (9) @(posedge clk);
        #1 check("irq_before_k9", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1 check("irq_at_k9", {31'h0, irq}, 32'h1);
        rd(3'd3, 32'h1, "capture_bit0");
        rd(3'd0, 32'h1, "data_bit0");
        wr(3'd3, 32'h1);
        check("irq_cleared_w1c", {31'h0, irq}, 32'h0);
        rd(3'd3, 32'h0, "capture_cleared");
        wr(3'd0, 32'h0);
        rd(3'd0, 32'h1, "data_readonly");

        // Glitch of 7 cycles on bit 2 is rejected
        wr(3'd4, 32'hF);
        @(negedge clk);
        in_port[2]  = 1'b1;
        bus.address = 3'd1;
        repeat (3) @(negedge clk);
        check("raw_shows_pulse", bus.readdata, 32'h5);
        repeat (4) @(negedge clk);
        in_port[2] = 1'b0;
        repeat (15) @(negedge clk);
        rd(3'd0, 32'h1, "glitch_data");
        rd(3'd3, 32'h0, "glitch_capture");
        rd(3'd1, 32'h1, "glitch_raw_back");

        // Falling-only on bit 1
        wr(3'd5, 32'h2);
        wr(3'd4, 32'h0);
        wr(3'd2, 32'h2);
        @(negedge clk);
        in_port[1] = 1'b1;
        repeat (20) @(negedge clk);
        rd(3'd0, 32'h3, "fall_data_high");
        rd(3'd3, 32'h0, "fall_no_rise_set");
        check("fall_irq_low", {31'h0, irq}, 32'h0);
        @(negedge clk);
        in_port[1] = 1'b0;
        repeat (20) @(negedge clk);
        rd(3'd3, 32'h2, "fall_capture");
        check("fall_irq_high", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h2);
        check("fall_irq_cleared", {31'h0, irq}, 32'h0);

        // Set and clear of bit 3 on the same edge: set wins
        wr(3'd4, 32'h8);
        wr(3'd2, 32'h8);
        @(negedge clk);
        in_port[3] = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("simul_irq_before", {31'h0, irq}, 32'h0);
        bus.address    = 3'd3;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = 32'h8;
        @(posedge clk);
        #1 check("simul_irq_set_wins", {31'h0, irq}, 32'h1);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        rd(3'd3, 32'h8, "simul_capture");
        check("simul_irq_holds", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h8);
        check("simul_irq_cleared", {31'h0, irq}, 32'h0);

        // Bits 0 and 3 fall together with everything enabled
        wr(3'd4, 32'hF);
        wr(3'd5, 32'hF);
        wr(3'd2, 32'hF);
        @(negedge clk);
        in_port = 4'h0;
        repeat (20) @(negedge clk);
        rd(3'd3, 32'h9, "multi_capture");
        rd(3'd0, 32'h0, "multi_data");
        wr(3'd3, 32'h1);
        rd(3'd3, 32'h8, "multi_partial_clear");
        check("multi_irq_holds", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h8);
        check("multi_irq_cleared", {31'h0, irq}, 32'h0);

        // Reset mid-debounce with bit 2 held high through release
        @(negedge clk);
        in_port = 4'h4;
        repeat (5) @(negedge clk);
        reset_n     = 1'b0;
        bus.address = 3'd0;
        #1 check("rst_mid_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("rst_data_not_yet", bus.readdata, 32'h0);
        @(posedge clk);
        #1 check("rst_data_updated", bus.readdata, 32'h4);
        rd(3'd3, 32'h4, "rst_fresh_capture");
        rd(3'd4, 32'hF, "rst_rise_en");
        rd(3'd2, 32'h0, "rst_mask");
        rd(3'd5, 32'h0, "rst_fall_en");
        check("rst_irq_masked", {31'h0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nios_fprint_button_pio_db.md
# nios_fprint_button_pio_db

Parametrised, debounced, multi-bit input PIO with an Avalon-MM slave, for the per-processor Nios subsystems in the fingerprinting system. It replaces single-bit button PIOs with a WIDTH-bit port that has the following features:
- two-flop synchronisation and per-bit debounce
- per-bit rising- and/or falling-edge selection
- write-1-to-clear edge capture
- a masked, level-sensitive interrupt to the Nios IRQ controller

## Interface
Parameters:
- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised bit must differ from its stable value before the stable value updates (>=1)
- INIT_LEVEL, 0 (WIDTH bits), reset value of the sync flops and the stable register

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH-1 ignored
- in_port  in  WIDTH  asynchronous button/switch inputs
- readdata  out  32  registered read data, zero-extended
- irq  out  1  interrupt request, active high

Reset: reset_n is asynchronous, active-low; clock is clk.

## Operation
- Synchroniser: per bit, d1 <= in_port, sync <= d1; both reset to INIT_LEVEL.
- Debounce: per bit, one counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If sync == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Else: counter <= counter+1.
  - A bit that returns to stable before the terminal count clears its counter; no update and no edge.
- Edge capture: on the clock edge where stable[i] updates, edge_capture[i] <= 1 under these conditions:
  - update is 0->1 and rise_en[i] = 1, or
  - update is 1->0 and fall_en[i] = 1.
- Clearing edge_capture:
  - A write to address 3 clears every bit whose writedata bit is 1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- irq = |(edge_capture & irq_mask). It is combinational from registers and stays high until the capture bits are cleared or masked.
- Register map (write = chipselect & ~write_n):
  - 0 data: stable value, read-only
  - 1 raw: sync value, read-only
  - 2 irq_mask: R/W
  - 3 edge_capture: read; write-1-to-clear
  - 4 rise_en: R/W
  - 5 fall_en: R/W
  - 6, 7: read 0; writes ignored
- Writes to read-only addresses have no effect.
- Reset values:
  - readdata = 0, irq = 0
  - irq_mask = 0, edge_capture = 0, fall_en = 0
  - rise_en = all ones
  - counters = 0
  - stable = INIT_LEVEL

## Timing
- Read latency is 1 cycle. readdata is loaded every clock edge from the mux selected by address, independent of chipselect.
- Write effects are visible on the edge that samples the write.
  - Reading the same register on the next cycle returns the new value.
- Input-to-stable latency: for an in_port change that is stable before edge k, the stable register updates at edge k+1+DEBOUNCE_CYCLES.
  - edge_capture and irq (if masked in) go high at that same edge.
- With DEBOUNCE_CYCLES = 1, stable updates at edge k+2.
- A pulse shorter than DEBOUNCE_CYCLES synchronised cycles is ignored entirely.
- Clearing rise_en/fall_en, or clearing a mask bit, does not clear captured edges. Clearing a mask bit drops irq on the next edge.
- Changing rise_en/fall_en affects only updates after the write edge.
- Reset asserted mid-debounce: everything returns to reset values immediately. An input held at a non-INIT_LEVEL value through reset is recognised as a fresh transition DEBOUNCE_CYCLES+2 edges after release.

## Test plan
- Reset with in_port = 0; read addresses 0–7 → 0, 0, 0, 0, 0xF, 0, 0, 0 (WIDTH = 4); irq = 0.
- DEBOUNCE_CYCLES = 8, mask = 0x1, rise_en = 0x1:
  - Drive in_port[0] high → irq rises exactly at edge k+9.
  - Read addr 3 → 0x1.
  - Write 0x1 to addr 3 → irq low on the next cycle.
- Glitch rejection: pulse in_port[2] high for 7 cycles (DEBOUNCE_CYCLES = 8) → data stays 0, edge_capture stays 0, raw shows the pulse.
- Falling-only: fall_en = 0x2, rise_en = 0, mask = 0x2. Toggle bit 1 high, then low, each held for 20 cycles → capture 0x2 only after the falling edge; no set on the rise.
- Simultaneous events: write 0x8 to addr 3 on the same edge that bit 3 debounces with rise_en[3] = 1 → edge_capture[3] = 1 and irq stays high.
- Multi-bit: bits 0 and 3 transition together, all masks set → capture 0x9. Write 0x1 to addr 3 → 0x8 remains and irq stays high. Write 0x8 → irq low.
